huffman_decoder: RTL and testbench



---
 rtl/huffman_decoder.sv | 120 ++++++++++++
 tb/tb_huffman_decoder.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/huffman_decoder.sv
// huffman_decoder: table-driven prefix-code decoder, 64 symbols, codes up to 8 bits.
// Ports:
//   clock, reset             rising-edge clock, asynchronous active-high reset
//   tbl_we/addr/code/len     table load (IDLE only); len 0 or >8 marks an entry invalid
//   start, flush             IDLE->RUN pulse; flush discards bits, clears error, returns to IDLE
//   encoded_in, enable_in    32-bit packed bitstream word, bit 31 first; taken when enable_in && ready_in
//   ready_in                 RUN and at most 32 bits buffered
//   symbol_out, symbol_valid decoded symbol and its one-cycle qualifier
//   error_out                high while halted on an undecodable prefix
//   sym_count                symbol counter, present only with HUFFMAN_DECODER_STATS_EN defined
module huffman_decoder (
    input  logic        clock,
    input  logic        reset,
    input  logic        tbl_we,
    input  logic [5:0]  tbl_addr,
    input  logic [7:0]  tbl_code,
    input  logic [3:0]  tbl_len,
    input  logic        start,
    input  logic [31:0] encoded_in,
    input  logic        enable_in,
    output logic        ready_in,
    input  logic        flush,
    output logic [5:0]  symbol_out,
    output logic        symbol_valid,
`ifdef HUFFMAN_DECODER_STATS_EN
    output logic [15:0] sym_count,
`endif
    output logic        error_out
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] HALT = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [7:0]  code_q [64];
    logic [3:0]  len_q [64];
    logic [63:0] buf_q, buf_d;
    logic [6:0]  cnt_q, cnt_d;
    logic [5:0]  sym_q, sym_d;
    logic        valid_q, valid_d;
    logic        hit, consume, accept;
    logic [5:0]  hit_idx;
    logic [3:0]  hit_len, used;
    logic [6:0]  cnt_mid;
    logic [63:0] shifted;

    assign ready_in     = (state_q == RUN) && (cnt_q <= 7'd32);
    assign accept       = enable_in && ready_in;
    assign error_out    = (state_q == HALT);
    assign symbol_out   = sym_q;
    assign symbol_valid = valid_q;

    // Scan from the top so the lowest matching index is the one left standing.
    always_comb begin
        hit     = 1'b0;
        hit_idx = 6'd0;
        hit_len = 4'd0;
        for (int i = 63; i >= 0; i--) begin
            if (len_q[i] >= 4'd1 && len_q[i] <= 4'd8 && {3'd0, len_q[i]} <= cnt_q &&
                (buf_q[63:56] >> (4'd8 - len_q[i])) == (code_q[i] & ~(8'hFF << len_q[i]))) begin
                hit     = 1'b1;
                hit_idx = 6'(i);
                hit_len = len_q[i];
            end
        end
    end

    // Consumption and append happen together: the new word lands right behind
    // whatever survives this cycle's shift, so straddling codes see no gap.
    always_comb begin
        consume = (state_q == RUN) && hit;
        used    = consume ? hit_len : 4'd0;
        cnt_mid = cnt_q - {3'd0, used};
        shifted = buf_q << used;
        state_d = flush ? IDLE :
                  (state_q == IDLE && start) ? RUN :
                  (state_q == RUN && !hit && cnt_q >= 7'd8) ? HALT : state_q;
        buf_d   = flush ? 64'd0 : accept ? (shifted | ({encoded_in, 32'd0} >> cnt_mid)) : shifted;
        cnt_d   = flush ? 7'd0 : accept ? cnt_mid + 7'd32 : cnt_mid;
        valid_d = !flush && consume;
        sym_d   = valid_d ? hit_idx : sym_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            buf_q   <= 64'd0;
            cnt_q   <= 7'd0;
            sym_q   <= 6'd0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
            sym_q   <= sym_d;
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 64; i++) begin
                code_q[i] <= 8'd0;
                len_q[i]  <= 4'd0;
            end
        end else if (!flush && state_q == IDLE && tbl_we) begin
            code_q[tbl_addr] <= tbl_code;
            len_q[tbl_addr]  <= tbl_len;
        end
    end

`ifdef HUFFMAN_DECODER_STATS_EN
    logic [15:0] stat_q;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) stat_q <= 16'd0;
        else       stat_q <= flush ? 16'd0 : stat_q + {15'd0, valid_d};
    end
    assign sym_count = stat_q;
`endif
endmodule

// File: tb/tb_huffman_decoder.sv
// tb_huffman_decoder: directed self-checking bench for huffman_decoder.
module tb_huffman_decoder;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        tbl_we = 1'b0;
    logic [5:0]  tbl_addr = '0;
    logic [7:0]  tbl_code = '0;
    logic [3:0]  tbl_len = '0;
    logic        start = 1'b0;
    logic [31:0] encoded_in = '0;
    logic        enable_in = 1'b0;
    logic        ready_in;
    logic        flush = 1'b0;
    logic [5:0]  symbol_out;
    logic        symbol_valid;
    logic        error_out;
`ifdef HUFFMAN_DECODER_STATS_EN
    logic [15:0] sym_count;
`endif

    huffman_decoder dut (
        .clock(clock), .reset(reset), .tbl_we(tbl_we), .tbl_addr(tbl_addr),
        .tbl_code(tbl_code), .tbl_len(tbl_len), .start(start), .encoded_in(encoded_in),
        .enable_in(enable_in), .ready_in(ready_in), .flush(flush), .symbol_out(symbol_out),
        .symbol_valid(symbol_valid),
`ifdef HUFFMAN_DECODER_STATS_EN
        .sym_count(sym_count),
`endif
        .error_out(error_out)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int acc_cyc = 0;
    logic [5:0] q[$];
    int cq[$];
    logic [5:0] expq[$];
    logic watch = 1'b0;
    logic saw_busy = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;
    always @(negedge clock) begin
        if (symbol_valid) begin
            q.push_back(symbol_out);
            cq.push_back(cyc);
        end
        if (watch && enable_in && !ready_in) saw_busy <= 1'b1;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic load(input logic [5:0] a, input logic [7:0] c, input logic [3:0] l);
        tbl_we = 1'b1; tbl_addr = a; tbl_code = c; tbl_len = l;
        tick();
        tbl_we = 1'b0;
    endtask

    task automatic load_std();
        load(6'd0, 8'b0, 4'd1);
        load(6'd1, 8'b10, 4'd2);
        load(6'd2, 8'b110, 4'd3);
        load(6'd3, 8'b111, 4'd3);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    // Leaves enable_in high so back-to-back words stream without a bubble.
    task automatic send(input logic [31:0] w);
        int n;
        n = 0;
        enable_in = 1'b1;
        encoded_in = w;
        while (!ready_in && n < 200) begin
            tick();
            n++;
        end
        if (n == 200) begin
            failures++;
            $display("FAIL send_timeout observed=not_ready expected=ready");
        end
        tick();
        acc_cyc = cyc;
    endtask

    task automatic push_bits(input logic [31:0] w);
        for (int i = 31; i >= 0; i--) expq.push_back(w[i] ? 6'd1 : 6'd0);
    endtask

    task automatic cmp_seq(input string tag);
        int n;
        chk({tag, "_count"}, q.size(), expq.size());
        n = (q.size() < expq.size()) ? q.size() : expq.size();
        for (int i = 0; i < n; i++) chk($sformatf("%s_sym%0d", tag, i), int'(q[i]), int'(expq[i]));
        if (q.size() > 0) chk({tag, "_nogap"}, cq[q.size()-1] - cq[0], q.size() - 1);
    endtask

    task automatic clear_obs();
        q.delete();
        cq.delete();
        expq.delete();
    endtask

    initial begin
        // Reset values
        #2 reset = 1'b1;
        #10;
        chk("rst_valid", int'(symbol_valid), 0);
        chk("rst_sym", int'(symbol_out), 0);
        chk("rst_err", int'(error_out), 0);
        chk("rst_ready", int'(ready_in), 0);
        tick();
        reset = 1'b0;
        tick();

        // Basic decode: 0,1,2,3 then 23 zeros, first symbol one edge after accept
        load_std();
        chk("idle_not_ready", int'(ready_in), 0);
        pulse_start();
        chk("run_ready", int'(ready_in), 1);
        clear_obs();
        send(32'h5B80_0000);
        enable_in = 1'b0;
        repeat (30) tick();
        expq = '{6'd0, 6'd1, 6'd2, 6'd3};
        repeat (23) expq.push_back(6'd0);
        cmp_seq("basic");
        if (cq.size() > 0) chk("latency", cq[0] - acc_cyc, 1);
        chk("basic_noerr", int'(error_out), 0);
`ifdef HUFFMAN_DECODER_STATS_EN
        chk("stats_27", int'(sym_count), 27);
        do_flush();
        chk("stats_flush", int'(sym_count), 0);
`endif

        // Two words back to back, then a code that straddles the word boundary
        do_flush();
        pulse_start();
        clear_obs();
        send(32'hFFFF_FFFE);
        send(32'h0000_0000);
        enable_in = 1'b0;
        repeat (50) tick();
        repeat (10) expq.push_back(6'd3);
        expq.push_back(6'd1);
        repeat (32) expq.push_back(6'd0);
        cmp_seq("two_words");

        do_flush();
        pulse_start();
        clear_obs();
        send(32'hFFFF_FFFF);
        send(32'h0000_0000);
        enable_in = 1'b0;
        repeat (50) tick();
        repeat (10) expq.push_back(6'd3);
        expq.push_back(6'd2);
        repeat (31) expq.push_back(6'd0);
        cmp_seq("straddle");

        // Flush beats start in the same cycle
        do_flush();
        flush = 1'b1; start = 1'b1;
        tick();
        flush = 1'b0; start = 1'b0;
        chk("flush_prio_start", int'(ready_in), 0);

        // Continuous enable with 1-bit codes: back-pressure without loss
        load(6'd1, 8'b1, 4'd1);
        pulse_start();
        clear_obs();
        saw_busy = 1'b0;
        watch = 1'b1;
        send(32'hA5C3_0F96); push_bits(32'hA5C3_0F96);
        send(32'h1234_5678); push_bits(32'h1234_5678);
        send(32'hDEAD_BEEF); push_bits(32'hDEAD_BEEF);
        send(32'h0000_FFFF); push_bits(32'h0000_FFFF);
        enable_in = 1'b0;
        watch = 1'b0;
        repeat (140) tick();
        chk("backpressure_seen", int'(saw_busy), 1);
        cmp_seq("stream");

        // Undecodable prefix halts
        reset = 1'b1;
        tick();
        reset = 1'b0;
        load(6'd0, 8'b0, 4'd1);
        pulse_start();
        clear_obs();
        send(32'hFF00_0000);
        enable_in = 1'b0;
        chk("pre_err", int'(error_out), 0);
        tick();
        chk("halt_err", int'(error_out), 1);
        chk("halt_ready", int'(ready_in), 0);
        pulse_start();
        repeat (5) tick();
        chk("halt_sticky", int'(error_out), 1);
        chk("halt_nosym", q.size(), 0);
        do_flush();
        chk("flush_err", int'(error_out), 0);
        chk("flush_idle", int'(ready_in), 0);
        chk("flush_valid", int'(symbol_valid), 0);

        // Reset mid-decode aborts and wipes the table
        load_std();
        pulse_start();
        send(32'h5B80_0000);
        enable_in = 1'b0;
        repeat (3) tick();
        #2 reset = 1'b1;
        #1;
        q.delete();
        cq.delete();
        chk("mid_rst_valid", int'(symbol_valid), 0);
        chk("mid_rst_sym", int'(symbol_out), 0);
        chk("mid_rst_err", int'(error_out), 0);
        chk("mid_rst_ready", int'(ready_in), 0);
        repeat (3) tick();
        reset = 1'b0;
        chk("mid_rst_nopulse", q.size(), 0);
        pulse_start();
        clear_obs();
        send(32'h5B80_0000);
        enable_in = 1'b0;
        repeat (10) tick();
        chk("wiped_nosym", q.size(), 0);
        chk("wiped_err", int'(error_out), 1);
        do_flush();
        load_std();
        pulse_start();
        clear_obs();
        send(32'h5B80_0000);
        enable_in = 1'b0;
        repeat (30) tick();
        expq = '{6'd0, 6'd1, 6'd2, 6'd3};
        repeat (23) expq.push_back(6'd0);
        cmp_seq("reload");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
